quad_decoder: RTL
=================

Name: quad_decoder

Overview:
- Quadrature (A/B) decoder with its own position counter; the receive-side counterpart to the team's up/down counter, deriving the count direction from an external incremental encoder instead of a direction input.
- Synchronises and glitch-filters both channels, decodes x4 Gray transitions into up/down steps, and maintains a wrapping position count.
- Detects illegal double-bit transitions and keeps a saturating error count.
- Sits between the encoder pins and motion/position logic.

Parameters:
- CNT_W, 16, width of position count.
- FILT_LEN, 3, consecutive clk samples a channel must hold a new value before acceptance; legal range 1..15.
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- quad_a  input  1  encoder channel A, asynchronous to clk.
- quad_b  input  1  encoder channel B, asynchronous to clk.
- clear  input  1  synchronous clear of count and err_cnt.
- count  output  CNT_W  signed-agnostic position count, wraps.
- dir  output  1  direction of last valid step (1 = up).
- step  output  1  one-cycle pulse per valid step.
- err  output  1  one-cycle pulse per illegal transition.
- err_cnt  output  ERR_W  saturating illegal-transition count.

Behaviour:
Reset:
- Reset is asynchronous, active-high; clock is clk.
- While reset is high: count = 0, dir = 0, step = 0, err = 0, err_cnt = 0, sync/filter/prev state = 00, filter counters = 0, FSM = INIT.

Input path:
- Each channel passes through a 2-flop synchroniser.
- Glitch filter per channel: the filtered bit takes the synchronised value on the FILT_LEN-th consecutive edge at which the synchronised value differs from the filtered bit.
- Any sample equal to the filtered bit resets that channel's filter counter to 0.

Latency:
- If the raw input is first captured at edge E, the filtered value changes at E+1+FILT_LEN.
- count, dir, step and err update at E+2+FILT_LEN (E+5 at default).

FSM INIT:
- Entered at reset.
- Lasts 2+FILT_LEN cycles after reset deassertion, counted by an arm counter.
- prev tracks the filtered {A,B} every cycle; no steps, no errors.
- Then transition to RUN.
- Purpose: power-up with inputs at 11 must not flag an error.

FSM RUN, each cycle compare prev vs filtered {A,B}, then prev <= filtered:
- Equal: no action.
- Up sequence 00→10→11→01→00: count += 1, dir = 1, step = 1.
- Down (reverse) sequence: count -= 1, dir = 0, step = 1.
- Both bits changed: err = 1; err_cnt += 1, saturating at 2^ERR_W−1; count and dir unchanged; no step.

Arithmetic:
- Modulo 2^CNT_W: all-ones + up → 0; 0 + down → all-ones.

Clear:
- clear high: count <= 0 and err_cnt <= 0 that edge, with priority over a simultaneous step or error.
- step, err and dir still reflect the decode in that cycle.
- The FSM is unaffected.

Reset mid-operation:
- Immediate return to reset values and INIT; in-flight filtered edges are discarded.

Decomposition:
- Shared package quad_pkg:
  - 2-bit phase constants PH_00, PH_10, PH_11, PH_01.
  - FSM state typedef {INIT, RUN}.
  - Helper function next_up_phase.
- One sub-module quad_input_filter (2-flop sync + FILT_LEN glitch filter), instantiated once per channel.
- Decode, FSM and counters live in quad_decoder.

Test Plan:
- Reset with A=B=0 held 20 cycles → count=0x0000, err_cnt=0, step never asserted, dir=0.
- Reset with A=B=1 held, release → no err pulse, err_cnt=0, count=0x0000.
- Forward 00→10→11→01→00, each phase held 8 cycles → count steps 1,2,3,4; dir=1; exactly 4 step pulses; each update 5 cycles after the raw edge.
- From count=0x0000, one reverse step 00→01 → count=0xFFFF, dir=0; then forward step 01→00 → count=0x0000, dir=1.
- Glitch: quad_a high for 2 cycles from phase 00 → no step, count unchanged; quad_a high for 3 cycles then low → count+1 followed by count−1 (two steps, net 0).
- Illegal jump 00→11 → one err pulse, err_cnt=1, count unchanged.
- 300 alternating illegal jumps → err_cnt=255 (saturated).
- clear asserted on the same edge as a valid up step at count=0x0010 → count=0x0000, err_cnt=0, step=1, dir=1.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and phase helpers for the quadrature decoder.
// Phases are encoded as {A,B}; the up direction walks 00->10->11->01->00.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef enum logic {INIT, RUN} state_t;

    function automatic logic [1:0] next_up_phase(input logic [1:0] ph);
        logic [1:0] nxt;
        nxt = PH_10;
        case (ph)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            PH_01:   nxt = PH_00;
            default: nxt = PH_10;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder channel: 2-flop synchroniser followed by a glitch filter.
// The filtered bit only moves after FILT_LEN consecutive differing samples.
module quad_input_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    logic       sync1;
    logic       sync2;
    logic [3:0] run_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            filt    <= 1'b0;
            run_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreeing sample restarts the run, so a glitch never accumulates.
            if (sync2 == filt) begin
                run_cnt <= '0;
            end else if (run_cnt == 4'(FILT_LEN - 1)) begin
                filt    <= sync2;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered A/B phases drive a wrapping position count,
// a direction flag and a saturating count of illegal double-bit transitions.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    // Covers the filter pipeline so a power-up level (e.g. 11) lands in prev
    // before any comparison is made.
    localparam int ARM_LEN = FILT_LEN + 2;

    logic       filt_a;
    logic       filt_b;
    logic [1:0] cur;
    logic [1:0] prev;
    logic [4:0] arm_cnt;
    state_t     state;
    state_t     state_nxt;
    logic       up;
    logic       down;
    logic       bad;

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .raw   (quad_a),
        .filt  (filt_a)
    );

    quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .raw   (quad_b),
        .filt  (filt_b)
    );

    assign cur = {filt_a, filt_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INIT;
            arm_cnt <= '0;
            prev    <= PH_00;
        end else begin
            state <= state_nxt;
            prev  <= cur;
            if (state == INIT && arm_cnt != 5'(ARM_LEN))
                arm_cnt <= arm_cnt + 5'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        up        = 1'b0;
        down      = 1'b0;
        bad       = 1'b0;
        case (state)
            INIT: begin
                if (arm_cnt == 5'(ARM_LEN))
                    state_nxt = RUN;
            end
            RUN: begin
                if (cur != prev) begin
                    if (cur == next_up_phase(prev))
                        up = 1'b1;
                    else if (prev == next_up_phase(cur))
                        down = 1'b1;
                    else
                        bad = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            dir     <= 1'b0;
            step    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            step <= up | down;
            err  <= bad;
            if (up | down)
                dir <= up;
            // clear wins over the decode, but pulses and dir still report it.
            if (clear)
                count <= '0;
            else if (up)
                count <= count + 1'b1;
            else if (down)
                count <= count - 1'b1;
            if (clear)
                err_cnt <= '0;
            else if (bad && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
